median_filter_stream: RTL and testbench

Streaming, parametrised sliding-window median filter. It accepts one unsigned sample per handshake and keeps the last WINDOW samples. For every accepted sample after the window has filled, it emits the window's median, minimum and maximum. It sits in the sample datapath between a valid/ready producer (ADC front-end or line buffer) and downstream processing, and replaces fixed five-input combinational median selection.

---
 rtl/median_filter_stream_if.sv | 27 ++
 rtl/median_filter_stream.sv | 138 +++++++++++++
 tb/tb_median_filter_stream.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/median_filter_stream_if.sv
// Sample/result stream bundle for median_filter_stream: one input stream of samples,
// one output stream of {median, min, max} results.
interface median_filter_stream_if #(
    parameter int WIDTH = 8
);
    // Valid/ready on both streams: a beat transfers on a rising edge where valid && ready.
    // A producer holds valid and data stable until that edge, and ready never depends on
    // valid from the same side.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_median;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_median, out_min, out_max
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_median, out_min, out_max
    );
endinterface

// File: rtl/median_filter_stream.sv
// Sliding-window median/min/max filter: shift-register window, rank-based selection,
// one stage of pending-result flag and a registered output stage.
module median_filter_stream #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    median_filter_stream_if.slave bus
);
    localparam int CW  = $clog2(WINDOW + 1);
    localparam int RW  = $clog2(WINDOW);
    localparam int MED = (WINDOW - 1) / 2;

    if ((WINDOW < 3) || (WINDOW > 15) || ((WINDOW % 2) == 0)) begin : g_bad_window
        $error("median_filter_stream: WINDOW must be odd and within 3..15");
    end

    logic [WIDTH-1:0] win_q [WINDOW];
    logic [WIDTH-1:0] win_d [WINDOW];
    logic [CW-1:0]    fill_q, fill_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] median_q, median_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;

    logic [RW-1:0]    rank [WINDOW];
    logic [WIDTH-1:0] sel_median, sel_min, sel_max;
    logic             in_ready;
    logic             accept;
    logic             produce;
    logic             load;

    // A full output register with a pending stage-1 result and no consumer stalls input.
    assign in_ready = !rst && !flush && (!s1_valid_q || !out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign produce  = accept && (fill_q >= CW'(WINDOW - 1));
    assign load     = s1_valid_q && (!out_valid_q || bus.out_ready);

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_median = median_q;
    assign bus.out_min    = min_q;
    assign bus.out_max    = max_q;

    // Equal samples are ordered by position, so ranks always form a permutation.
    always_comb begin
        for (int i = 0; i < WINDOW; i++) begin
            rank[i] = '0;
            for (int j = 0; j < WINDOW; j++) begin
                if ((j != i) &&
                    ((win_q[j] < win_q[i]) || ((win_q[j] == win_q[i]) && (j < i)))) begin
                    rank[i] = rank[i] + RW'(1);
                end
            end
        end
        sel_median = '0;
        sel_min    = '0;
        sel_max    = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (rank[i] == RW'(MED))        sel_median = win_q[i];
            if (rank[i] == '0)              sel_min    = win_q[i];
            if (rank[i] == RW'(WINDOW - 1)) sel_max    = win_q[i];
        end
    end

    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        median_d    = median_q;
        min_d       = min_q;
        max_d       = max_q;

        if (accept) begin
            win_d[0] = bus.in_data;
            for (int i = 1; i < WINDOW; i++) begin
                win_d[i] = win_q[i-1];
            end
            if (fill_q != CW'(WINDOW)) begin
                fill_d = fill_q + CW'(1);
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            s1_valid_d  = 1'b0;
            median_d    = sel_median;
            min_d       = sel_min;
            max_d       = sel_max;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new result entering stage 1 overrides the clear caused by a load.
        if (produce) begin
            s1_valid_d = 1'b1;
        end

        // Flush drops the window and every pending result but keeps the last output data.
        if (flush) begin
            for (int i = 0; i < WINDOW; i++) begin
                win_d[i] = '0;
            end
            fill_d      = '0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            median_d    = median_q;
            min_d       = min_q;
            max_d       = max_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                win_q[i] <= '0;
            end
            fill_q      <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            median_q    <= '0;
            min_q       <= '0;
            max_q       <= '0;
        end else begin
            win_q       <= win_d;
            fill_q      <= fill_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            median_q    <= median_d;
            min_q       <= min_d;
            max_q       <= max_d;
        end
    end
endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream (WIDTH=8, WINDOW=5) with an in-order
// result scoreboard fed from hand-computed expectations.
module tb_median_filter_stream;
    localparam int WIDTH  = 8;
    localparam int WINDOW = 5;

    logic clk;
    logic rst;
    logic flush;

    median_filter_stream_if #(.WIDTH(WIDTH)) bus ();

    median_filter_stream #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt;
    logic [23:0] exp_q [$];
    logic [23:0] mon_got;
    logic [23:0] mon_exp;

    // Clock and global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] med, input logic [7:0] mn, input logic [7:0] mx);
        exp_q.push_back({med, mn, mx});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one sample and waits (bounded) until it is accepted; returns on the next negedge.
    task automatic send(input logic [7:0] d);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!acc && (n < 200)) begin
            #1;
            acc = bus.in_ready;
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check_eq("send_timeout", 32'(acc), 1);
    endtask

    task automatic warm_up(input string tag);
        push_exp(30, 10, 50);
        send(10);
        send(50);
        send(30);
        send(20);
        #1 check_eq({tag, "_no_early_valid"}, 32'(bus.out_valid), 0);
        send(40);
        #1 check_eq({tag, "_lat_edge1"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        #1 check_eq({tag, "_lat_edge2"}, 32'(bus.out_valid), 1);
        @(negedge clk);
        #1 check_eq({tag, "_single_result"}, 32'(bus.out_valid), 0);
        @(negedge clk);
    endtask

    // Scoreboard: a result is consumed on the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        #2;
        if (bus.out_valid && bus.out_ready) begin
            mon_got = {bus.out_median, bus.out_min, bus.out_max};
            check_eq("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("result_value", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_median", 32'(bus.out_median), 0);
        check_eq("rst_min", 32'(bus.out_min), 0);
        check_eq("rst_max", 32'(bus.out_max), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("post_rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        warm_up("warm");

        // Sliding window
        push_exp(30, 5, 50);
        push_exp(30, 5, 45);
        send(5);
        #1 check_eq("slide_lat", 32'(bus.out_valid), 0);
        send(45);
        #1;
        check_eq("slide_med", 32'(bus.out_median), 30);
        check_eq("slide_min", 32'(bus.out_min), 5);
        check_eq("slide_max", 32'(bus.out_max), 50);
        @(negedge clk);

        // Ties, then extremes, with random idle gaps
        push_exp(20, 5, 45);
        push_exp(7, 5, 45);
        push_exp(7, 5, 45);
        push_exp(7, 3, 45);
        push_exp(7, 3, 9);
        push_exp(7, 0, 9);
        push_exp(7, 0, 255);
        push_exp(3, 0, 255);
        push_exp(9, 0, 255);
        push_exp(0, 0, 255);
        send(7);   idle($urandom_range(0, 2));
        send(7);   idle($urandom_range(0, 2));
        send(7);   idle($urandom_range(0, 2));
        send(3);   idle($urandom_range(0, 2));
        send(9);   idle($urandom_range(0, 2));
        send(0);   idle($urandom_range(0, 2));
        send(255); idle($urandom_range(0, 2));
        send(0);   idle($urandom_range(0, 2));
        send(255); idle($urandom_range(0, 2));
        send(0);
        idle(3);
        check_eq("drain_ties", 32'(exp_q.size()), 0);

        // Backpressure: output register full, one extra accept fills stage 1
        push_exp(100, 0, 255);
        push_exp(60, 0, 255);
        push_exp(60, 0, 255);
        push_exp(60, 0, 200);
        bus.out_ready = 1'b0;
        send(100);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 60;
        acc_cnt      = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.in_ready) acc_cnt++;
            check_eq("bp_hold_valid", 32'(bus.out_valid), 1);
            check_eq("bp_hold_med", 32'(bus.out_median), 100);
            check_eq("bp_hold_max", 32'(bus.out_max), 255);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("bp_accepts", 32'(acc_cnt), 1);
        #1 check_eq("bp_in_ready_low", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        send(20);
        send(200);
        idle(3);
        check_eq("drain_bp", 32'(exp_q.size()), 0);

        // Flush
        push_exp(60, 1, 200);
        push_exp(20, 1, 200);
        push_exp(3, 1, 200);
        send(1);
        send(2);
        send(3);
        idle(3);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 99;
        #1 check_eq("flush_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("flush_out_valid", 32'(bus.out_valid), 0);
        check_eq("flush_hold_med", 32'(bus.out_median), 3);
        @(negedge clk);
        send(11);
        send(22);
        send(33);
        send(44);
        idle(2);
        #1 check_eq("flush_refill_quiet", 32'(bus.out_valid), 0);
        @(negedge clk);
        push_exp(33, 11, 55);
        send(55);
        idle(3);
        check_eq("drain_flush", 32'(exp_q.size()), 0);

        // Reset with a result pending in the output register
        bus.out_ready = 1'b0;
        send(77);
        @(negedge clk);
        #1;
        check_eq("rstmid_pending_valid", 32'(bus.out_valid), 1);
        check_eq("rstmid_pending_med", 32'(bus.out_median), 44);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rstmid_out_valid", 32'(bus.out_valid), 0);
        check_eq("rstmid_median", 32'(bus.out_median), 0);
        check_eq("rstmid_min", 32'(bus.out_min), 0);
        check_eq("rstmid_max", 32'(bus.out_max), 0);
        check_eq("rstmid_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1 check_eq("rstmid_release_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        warm_up("rewarm");

        idle(3);
        check_eq("final_drain", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
